gs_sequencer: RTL and testbench

GS_SEQUENCER -- requirements
Module: gs_sequencer

---
 rtl/gs_pkg.sv | 18 +
 rtl/gs_sequencer_if.sv | 30 +++
 rtl/gs_pair_gen.sv | 38 +++
 rtl/gs_sequencer.sv | 110 +++++++++++
 tb/tb_gs_sequencer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/gs_pkg.sv
// Shared constants and state encoding for the Gram-Schmidt column-pass sequencer.
package gs_pkg;

  localparam int N_COLS      = 4;
  localparam int COL_W       = 2;
  localparam int UPD_LAT_DEF = 40;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DOT  = 3'd1,
    ST_UPD  = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4
  } gs_state_e;

  typedef logic [COL_W-1:0] col_t;

endpackage

// File: rtl/gs_sequencer_if.sv
// Control/handshake bundle between the sequencer and the dot/update/column-store datapath.
interface gs_sequencer_if;
  import gs_pkg::*;

  // Handshake: start is a level sampled only in IDLE. dot_valid is sampled only while
  // dot_en=1 and completes that phase on the edge where it is 1. abort beats everything.
  logic       start;
  logic       abort;
  logic       dot_en;
  logic       dot_valid;
  logic       upd_en;
  col_t       sel_i;
  col_t       sel_j;
  logic       wr_en;
  col_t       wr_col;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;

  modport slave (
    input  start, abort, dot_valid,
    output dot_en, upd_en, sel_i, sel_j, wr_en, wr_col, busy, done, dbg_state
  );

  modport master (
    output start, abort, dot_valid,
    input  dot_en, upd_en, sel_i, sel_j, wr_en, wr_col, busy, done, dbg_state
  );

endinterface

// File: rtl/gs_pair_gen.sv
// Walks the (i,j) column pairs (0,1),(0,2),(0,3),(1,2),(1,3),(2,3) and flags the last one.
module gs_pair_gen
  import gs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic adv,
  input  logic clr,
  output col_t sel_i,
  output col_t sel_j,
  output logic last
);

  assign last = (sel_i == 2'd2) && (sel_j == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_i <= '0;
      sel_j <= '0;
    end else if (load) begin
      sel_i <= 2'd0;
      sel_j <= 2'd1;
    end else if (clr) begin
      sel_i <= '0;
      sel_j <= '0;
    end else if (adv) begin
      // Wrapping j starts the next pivot row just right of the new pivot.
      if (sel_j == 2'd3) begin
        sel_i <= sel_i + 2'd1;
        sel_j <= sel_i + 2'd2;
      end else begin
        sel_j <= sel_j + 2'd1;
      end
    end
  end

endmodule

// File: rtl/gs_sequencer.sv
// Orchestrates one 4-column orthogonalization pass: dot product, timed column update, write-back.
module gs_sequencer
  import gs_pkg::*;
#(
  parameter int UPD_LAT = UPD_LAT_DEF
) (
  input logic          clk,
  input logic          rst_n,
  gs_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_DOT  = ST_DOT;
  localparam logic [2:0] S_UPD  = ST_UPD;
  localparam logic [2:0] S_WB   = ST_WB;
  localparam logic [2:0] S_DONE = ST_DONE;

  localparam logic [7:0] UPD_LOAD = 8'(UPD_LAT - 1);

  logic [2:0] state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       load, adv, clr, last;
  col_t       sel_i, sel_j;
  logic       dot_en_q, upd_en_q, wr_en_q, busy_q, done_q;
  col_t       wr_col_q;

  gs_pair_gen u_pair_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .adv   (adv),
    .clr   (clr),
    .sel_i (sel_i),
    .sel_j (sel_j),
    .last  (last)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    adv      = 1'b0;
    clr      = 1'b0;
    if (bus.abort && state != S_IDLE) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      clr      = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: if (bus.start && !bus.abort) begin
          state_nx = S_DOT;
          load     = 1'b1;
        end
        S_DOT: if (bus.dot_valid) begin
          state_nx = S_UPD;
          cnt_nx   = UPD_LOAD;
        end
        S_UPD: begin
          if (cnt == 8'd0) state_nx = S_WB;
          else             cnt_nx   = cnt - 8'd1;
        end
        S_WB: begin
          if (last) begin
            state_nx = S_DONE;
            clr      = 1'b1;
          end else begin
            state_nx = S_DOT;
            adv      = 1'b1;
          end
        end
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so every enable leaves a flop glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dot_en_q <= 1'b0;
      upd_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      wr_col_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      dot_en_q <= (state_nx == S_DOT);
      upd_en_q <= (state_nx == S_UPD);
      wr_en_q  <= (state_nx == S_WB);
      wr_col_q <= (state_nx == S_WB) ? sel_j : '0;
      busy_q   <= (state_nx == S_DOT) || (state_nx == S_UPD) || (state_nx == S_WB);
      done_q   <= (state_nx == S_DONE);
    end
  end

  assign bus.dot_en    = dot_en_q;
  assign bus.upd_en    = upd_en_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_col    = wr_col_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sel_i     = sel_i;
  assign bus.sel_j     = sel_j;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_gs_sequencer.sv
// Cycle-exact bench for gs_sequencer: expected output words come from a per-pair schedule model.
module tb_gs_sequencer;
  import gs_pkg::*;

  localparam int LAT = 4;
  localparam int W   = 11;
  localparam logic [W-1:0] IDLE_W = '0;

  typedef struct {
    logic         start;
    logic         abort;
    logic         dot_valid;
    logic [W-1:0] exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gs_sequencer_if bus ();

  gs_sequencer #(.UPD_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [W-1:0] out_w;
  assign out_w = {bus.dot_en, bus.upd_en, bus.wr_en, bus.busy, bus.done,
                  bus.sel_i, bus.sel_j, bus.wr_col};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [2:0]   in_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  int zero_st[6];
  int ten_st[6];
  int rnd_st[6];
  vec_t tbl[8];

  // Expected output word: {dot_en, upd_en, wr_en, busy, done, sel_i, sel_j, wr_col}
  function automatic logic [W-1:0] ow(input logic dot, input logic upd, input logic wr,
                                      input logic done, input logic [1:0] si,
                                      input logic [1:0] sj);
    return {dot, upd, wr, (dot | upd | wr), done, si, sj, (wr ? sj : 2'd0)};
  endfunction

  function automatic vec_t mk(input logic s, input logic a, input logic d,
                              input logic [W-1:0] e);
    vec_t v;
    v.start = s; v.abort = a; v.dot_valid = d; v.exp = e;
    return v;
  endfunction

  task automatic push(input vec_t v);
    in_q.push_back({v.start, v.abort, v.dot_valid});
    exp_q.push_back(v.exp);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_queue();
    logic [W-1:0] e;
    logic [2:0]   in;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e  = exp_q.pop_front();
      in = in_q.pop_front();
      check($sformatf("cycle_vec%0d", vec_cnt), out_w, e);
      {bus.start, bus.abort, bus.dot_valid} = in;
    end
  endtask

  task automatic push_idle(input int n, input bit noisy);
    for (int k = 0; k < n; k++)
      push(mk(1'b0, noisy ? 1'($urandom_range(0, 1)) : 1'b0,
              noisy ? 1'($urandom_range(0, 1)) : 1'b0, IDLE_W));
  endtask

  // Reference model: a pass is a start cycle, then per pair (stall+1) dot cycles,
  // LAT update cycles and one write-back, then a done cycle and a quiet idle cycle.
  // abort_at truncates the pass after that cycle; stop_at just cuts the schedule.
  task automatic gen_pass(input int stall[6], input int abort_at, input int start_at,
                          input int stop_at);
    vec_t p[$];
    int   k;
    p.push_back(mk(1'b1, 1'b0, 1'b0, IDLE_W));
    k = 0;
    for (int i = 0; i < N_COLS - 1; i++) begin
      for (int j = i + 1; j < N_COLS; j++) begin
        for (int d = 0; d <= stall[k]; d++)
          p.push_back(mk(1'b0, 1'b0, (d == stall[k]),
                         ow(1'b1, 1'b0, 1'b0, 1'b0, 2'(i), 2'(j))));
        for (int u = 0; u < LAT; u++)
          p.push_back(mk(1'b0, 1'b0, 1'($urandom_range(0, 1)),
                         ow(1'b0, 1'b1, 1'b0, 1'b0, 2'(i), 2'(j))));
        p.push_back(mk(1'b0, 1'b0, 1'($urandom_range(0, 1)),
                       ow(1'b0, 1'b0, 1'b1, 1'b0, 2'(i), 2'(j))));
        k++;
      end
    end
    p.push_back(mk(1'b0, 1'b0, 1'b0, ow(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0)));
    p.push_back(mk(1'b0, 1'b0, 1'b0, IDLE_W));
    if (start_at >= 0) p[start_at].start = 1'b1;
    if (abort_at >= 0) begin
      p[abort_at].abort = 1'b1;
      while (p.size() > abort_at + 1) void'(p.pop_back());
      p.push_back(mk(1'b0, 1'b0, 1'b0, IDLE_W));
    end
    if (stop_at >= 0)
      while (p.size() > stop_at + 1) void'(p.pop_back());
    foreach (p[n]) push(p[n]);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test ----------------
  initial begin
    int len, ab, st;

    foreach (zero_st[n]) begin
      zero_st[n] = 0;
      ten_st[n]  = 10;
    end

    // IDLE/DOT corner table: start+abort, stray dot_valid, start, ignored start, abort.
    tbl[0] = mk(1'b1, 1'b1, 1'b0, IDLE_W);
    tbl[1] = mk(1'b0, 1'b0, 1'b1, IDLE_W);
    tbl[2] = mk(1'b0, 1'b1, 1'b0, IDLE_W);
    tbl[3] = mk(1'b1, 1'b0, 1'b0, IDLE_W);
    tbl[4] = mk(1'b0, 1'b0, 1'b0, ow(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1));
    tbl[5] = mk(1'b1, 1'b0, 1'b0, ow(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1));
    tbl[6] = mk(1'b0, 1'b1, 1'b1, ow(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1));
    tbl[7] = mk(1'b0, 1'b0, 1'b0, IDLE_W);

    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.dot_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", out_w, IDLE_W);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 8; n++) push(tbl[n]);
    run_queue();

    // Clean pass, then a start pulse injected during UPD of (0,2) (no effect).
    gen_pass(zero_st, -1, -1, -1);
    gen_pass(zero_st, -1, 9, -1);
    // Ten stall cycles per pair.
    gen_pass(ten_st, -1, -1, -1);
    // Abort during UPD of (1,2), then a fresh pass from (0,1).
    gen_pass(zero_st, 21, -1, -1);
    gen_pass(zero_st, -1, -1, -1);
    run_queue();

    // Asynchronous reset during WB of (0,3).
    gen_pass(zero_st, -1, -1, 18);
    run_queue();
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", out_w, IDLE_W);
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(3, 1'b0);
    gen_pass(zero_st, -1, -1, -1);
    run_queue();

    // Randomized passes: stalls, idle gaps with noise, stray starts, aborts.
    repeat (30) begin
      push_idle(int'($urandom_range(0, 3)), 1'b1);
      len = 3;
      foreach (rnd_st[n]) begin
        rnd_st[n] = int'($urandom_range(0, 5));
        len += rnd_st[n] + 1 + LAT + 1;
      end
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 2)) : -1;
      st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len - 2)) : -1;
      gen_pass(rnd_st, ab, st, -1);
      run_queue();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
